// File: rtl/lcd_arbiter.sv
// lcd_arbiter: HD44780 power-up sequencer and two-port round-robin byte writer.
// Ports: clock/reset, req/rs/data/ack per requester, LCD_* bus, init_done, busy.
module lcd_arbiter #(
  parameter int T_PWRUP = 375000,
  parameter int T_SU    = 2,
  parameter int T_EN    = 12,
  parameter int T_HOLD  = 2,
  parameter int T_SHORT = 1000,
  parameter int T_LONG  = 41000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] LCD_data,
  output logic       LCD_rs,
  output logic       LCD_en,
  output logic       LCD_rw,
  output logic       init_done,
  output logic       busy
);

  localparam int M0 = (T_PWRUP > T_LONG) ? T_PWRUP : T_LONG;
  localparam int M1 = (T_SHORT > T_EN) ? T_SHORT : T_EN;
  localparam int M2 = (T_SU > T_HOLD) ? T_SU : T_HOLD;
  localparam int M3 = (M1 > M2) ? M1 : M2;
  localparam int TMAX = (M0 > M3) ? M0 : M3;
  localparam int CW = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    PWRUP, SETUP, PULSE, HOLD, EXEC, IDLE
  } state_t;

  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [1:0]    r_idx, w_idx;
  logic          r_rs, w_rs;
  logic [7:0]    r_data, w_data;
  logic          r_ack0, w_ack0;
  logic          r_ack1, w_ack1;
  logic          r_done, w_done;
  logic          r_last, w_last;
  logic          w_long, w_g0, w_g1;
  logic [CW-1:0] w_wait;

  function automatic logic [7:0] f_init(
    input logic [1:0] i
  );
    logic [7:0] b;
    unique case (i)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h06;
      default: b = 8'h01;
    endcase
    return b;
  endfunction

  // clear/home (0x01..0x03 as commands) need the long wait
  assign w_long = !r_rs && (r_data[7:2] == 6'd0)
                  && (r_data[1:0] != 2'd0);
  assign w_wait = w_long ? CW'(T_LONG - 1)
                         : CW'(T_SHORT - 1);

  // r_last names the port served last; the other wins a tie
  assign w_g0 = req0 && (!req1 || r_last);
  assign w_g1 = req1 && (!req0 || !r_last);

  always_comb begin
    w_nxt  = r_state;
    w_cnt  = r_cnt + 1'b1;
    w_idx  = r_idx;
    w_rs   = r_rs;
    w_data = r_data;
    w_ack0 = 1'b0;
    w_ack1 = 1'b0;
    w_done = r_done;
    w_last = r_last;
    unique case (r_state)
      PWRUP: begin
        if (r_cnt == CW'(T_PWRUP - 1)) begin
          w_nxt  = SETUP;
          w_cnt  = '0;
          w_idx  = 2'd0;
          w_rs   = 1'b0;
          w_data = f_init(2'd0);
        end
      end
      SETUP: begin
        if (r_cnt == CW'(T_SU - 1)) begin
          w_nxt = PULSE;
          w_cnt = '0;
        end
      end
      PULSE: begin
        if (r_cnt == CW'(T_EN - 1)) begin
          w_nxt = HOLD;
          w_cnt = '0;
        end
      end
      HOLD: begin
        if (r_cnt == CW'(T_HOLD - 1)) begin
          w_nxt = EXEC;
          w_cnt = '0;
        end
      end
      EXEC: begin
        if (r_cnt == w_wait) begin
          w_cnt = '0;
          if (r_done) begin
            w_nxt = IDLE;
          end else if (r_idx == 2'd3) begin
            w_nxt  = IDLE;
            w_done = 1'b1;
          end else begin
            w_nxt  = SETUP;
            w_idx  = r_idx + 2'd1;
            w_data = f_init(r_idx + 2'd1);
          end
        end
      end
      IDLE: begin
        w_cnt = '0;
        unique case (1'b1)
          w_g0: begin
            w_nxt  = SETUP;
            w_ack0 = 1'b1;
            w_rs   = rs0;
            w_data = data0;
            w_last = 1'b0;
          end
          w_g1: begin
            w_nxt  = SETUP;
            w_ack1 = 1'b1;
            w_rs   = rs1;
            w_data = data1;
            w_last = 1'b1;
          end
          default: ;
        endcase
      end
      default: w_nxt = PWRUP;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= PWRUP;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_done  <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_rs    <= w_rs;
      r_data  <= w_data;
      r_ack0  <= w_ack0;
      r_ack1  <= w_ack1;
      r_done  <= w_done;
      r_last  <= w_last;
    end
  end

  // decoded from the state register so reset drops LCD_en at once
  assign LCD_en    = (r_state == PULSE);
  assign busy      = (r_state != IDLE);
  assign LCD_rw    = 1'b0;
  assign LCD_rs    = r_rs;
  assign LCD_data  = r_data;
  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign init_done = r_done;

endmodule

// File: tb/tb_lcd_arbiter.sv
// tb_lcd_arbiter: directed bench for lcd_arbiter.
// Walks power-up, grants, round-robin, wait lengths, mid-pulse reset.
module tb_lcd_arbiter;

  localparam int T_PWRUP = 20;
  localparam int T_SU    = 2;
  localparam int T_EN    = 3;
  localparam int T_HOLD  = 2;
  localparam int T_SHORT = 5;
  localparam int T_LONG  = 9;

  logic       clock;
  logic       reset;
  logic       req0, req1, rs0, rs1;
  logic [7:0] data0, data1;
  logic       ack0, ack1;
  logic [7:0] LCD_data;
  logic       LCD_rs, LCD_en, LCD_rw;
  logic       init_done, busy;

  int n_checks = 0;
  int n_err    = 0;

  lcd_arbiter #(
    .T_PWRUP(T_PWRUP),
    .T_SU(T_SU),
    .T_EN(T_EN),
    .T_HOLD(T_HOLD),
    .T_SHORT(T_SHORT),
    .T_LONG(T_LONG)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req0(req0),
    .req1(req1),
    .rs0(rs0),
    .rs1(rs1),
    .data0(data0),
    .data1(data1),
    .ack0(ack0),
    .ack1(ack1),
    .LCD_data(LCD_data),
    .LCD_rs(LCD_rs),
    .LCD_en(LCD_en),
    .LCD_rw(LCD_rw),
    .init_done(init_done),
    .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // entered on the first SETUP sample; returns on the sample after EXEC
  task automatic bus_cycle(
    input string      tag,
    input logic [7:0] d,
    input logic       rs,
    input logic       lng,
    input logic [1:0] ack_first,
    input logic       keep
  );
    int n;
    int b_en, b_bus, b_busy, b_ack;
    logic       e_en;
    logic [1:0] e_ack;
    n = T_SU + T_EN + T_HOLD + (lng ? T_LONG : T_SHORT);
    b_en = 0; b_bus = 0; b_busy = 0; b_ack = 0;
    for (int k = 0; k < n; k++) begin
      e_en = (k >= T_SU) && (k < T_SU + T_EN);
      e_ack = (k == 0) ? ack_first : 2'b00;
      if (LCD_en !== e_en) b_en++;
      if (LCD_data !== d || LCD_rs !== rs
          || LCD_rw !== 1'b0) b_bus++;
      if (busy !== 1'b1) b_busy++;
      if ({ack1, ack0} !== e_ack) b_ack++;
      if (k == 0 && !keep) begin
        if (ack_first[0]) req0 = 1'b0;
        if (ack_first[1]) req1 = 1'b0;
      end
      tick();
    end
    chk({tag, "_en"}, 32'(b_en), 32'd0);
    chk({tag, "_bus"}, 32'(b_bus), 32'd0);
    chk({tag, "_busy"}, 32'(b_busy), 32'd0);
    chk({tag, "_ack"}, 32'(b_ack), 32'd0);
  endtask

  // entered on the sample where reset is released
  task automatic init_seq(input string tag);
    int b;
    b = 0;
    for (int k = 0; k < T_PWRUP; k++) begin
      if (LCD_en !== 1'b0 || busy !== 1'b1
          || init_done !== 1'b0
          || LCD_data !== 8'h00) b++;
      tick();
    end
    chk({tag, "_pwrup"}, 32'(b), 32'd0);
    bus_cycle({tag, "_38"}, 8'h38, 1'b0, 1'b0, 2'b00, 1'b1);
    bus_cycle({tag, "_0c"}, 8'h0C, 1'b0, 1'b0, 2'b00, 1'b1);
    bus_cycle({tag, "_06"}, 8'h06, 1'b0, 1'b0, 2'b00, 1'b1);
    bus_cycle({tag, "_01"}, 8'h01, 1'b0, 1'b1, 2'b00, 1'b1);
    chk({tag, "_done"}, 32'(init_done), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_noack"}, 32'({ack1, ack0}), 32'd0);
  endtask

  initial begin
    req0 = 1'b0; req1 = 1'b0;
    rs0 = 1'b0; rs1 = 1'b0;
    data0 = 8'h00; data1 = 8'h00;
    reset = 1'b1;
    #3 reset = 1'b0;
    tick();
    tick();
    chk("rst_en", 32'(LCD_en), 32'd0);
    chk("rst_rs", 32'(LCD_rs), 32'd0);
    chk("rst_data", 32'(LCD_data), 32'd0);
    chk("rst_ack", 32'({ack1, ack0}), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rw", 32'(LCD_rw), 32'd0);

    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h35;
    reset = 1'b1;
    init_seq("init1");

    tick();
    bus_cycle("u0", 8'h35, 1'b1, 1'b0, 2'b01, 1'b0);
    chk("u0_idle", 32'(busy), 32'd0);

    req1 = 1'b1; rs1 = 1'b0; data1 = 8'h01;
    tick();
    bus_cycle("u1", 8'h01, 1'b0, 1'b1, 2'b10, 1'b0);
    chk("u1_idle", 32'(busy), 32'd0);

    req1 = 1'b1; rs1 = 1'b0; data1 = 8'hC0;
    tick();
    bus_cycle("u2", 8'hC0, 1'b0, 1'b0, 2'b10, 1'b0);
    chk("u2_idle", 32'(busy), 32'd0);

    req0 = 1'b1; rs0 = 1'b1; data0 = 8'hA5;
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'h5A;
    tick();
    bus_cycle("rr0", 8'hA5, 1'b1, 1'b0, 2'b01, 1'b1);
    chk("rr0_idle", 32'(busy), 32'd0);
    tick();
    bus_cycle("rr1", 8'h5A, 1'b1, 1'b0, 2'b10, 1'b1);
    chk("rr1_idle", 32'(busy), 32'd0);
    tick();
    bus_cycle("rr2", 8'hA5, 1'b1, 1'b0, 2'b01, 1'b1);
    chk("rr2_idle", 32'(busy), 32'd0);
    tick();
    bus_cycle("rr3", 8'h5A, 1'b1, 1'b0, 2'b10, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("rr_stop_ack", 32'({ack1, ack0}), 32'd0);
    chk("rr_stop_busy", 32'(busy), 32'd0);
    chk("rr_hold_data", 32'(LCD_data), 32'h5A);

    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h77;
    tick();
    chk("mr_ack", 32'(ack0), 32'd1);
    req0 = 1'b0;
    repeat (T_SU) tick();
    chk("mr_pulse", 32'(LCD_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mr_en", 32'(LCD_en), 32'd0);
    chk("mr_done", 32'(init_done), 32'd0);
    chk("mr_busy", 32'(busy), 32'd1);
    chk("mr_data", 32'(LCD_data), 32'd0);
    tick();
    reset = 1'b1;
    init_seq("init2");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
